cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single registered common data bus (CDB) broadcast port among the integer functional units (ALU, MDU, later LSU). Each cycle it grants one valid requester, accepts its writeback packet (rob_id, rd_arch, rd_phy, rd_value), and drives it onto the CDB one cycle later. The CDB feeds the PRF write port, RS wakeup, RAT and ROB completion. The arbiter also keeps a saturating conflict counter for performance tuning.

---
 rtl/cdb_arbiter.sv | 95 +++++++++
 tb/tb_cdb_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter onto a single registered CDB; 1-cycle latency (grant in N, broadcast in N+1).
// Backpressure: the CDB never stalls; losing requesters see req_ready=0 and hold their payload.
module cdb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ROB_IDX = 5,
    parameter int PRF_IDX = 6,
    parameter int ARF_IDX = 5,
    localparam int SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ROB_IDX-1:0] req_rob_id,
    input  logic [NUM_REQ*ARF_IDX-1:0] req_rd_arch,
    input  logic [NUM_REQ*PRF_IDX-1:0] req_rd_phy,
    input  logic [NUM_REQ*32-1:0]      req_rd_value,
    output logic                       cdb_valid,
    output logic [ROB_IDX-1:0]         cdb_rob_id,
    output logic [ARF_IDX-1:0]         cdb_rd_arch,
    output logic [PRF_IDX-1:0]         cdb_rd_phy,
    output logic [31:0]                cdb_rd_value,
    output logic [SRC_W-1:0]           cdb_src,
    output logic [31:0]                perf_conflict_cnt
);

    typedef struct packed {
        logic [ROB_IDX-1:0] rob_id;
        logic [ARF_IDX-1:0] rd_arch;
        logic [PRF_IDX-1:0] rd_phy;
        logic [31:0]        rd_value;
    } pkt_t;

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] idx;
    logic             win_any;
    logic             hs;
    pkt_t             win_pkt;
    pkt_t             cdb_q;
    logic [SRC_W-1:0] src_q;

    // First valid requester scanning upward from rr_ptr with wrap.
    always_comb begin
        winner  = '0;
        win_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!win_any && req_valid[idx]) begin
                win_any = 1'b1;
                winner  = idx;
            end
        end
    end

    // Grant depends only on valid, rr_ptr, flush and rst, never on payload.
    assign hs        = win_any & ~flush & ~rst;
    assign req_ready = hs ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        win_pkt          = '0;
        win_pkt.rob_id   = req_rob_id[int'(winner)*ROB_IDX +: ROB_IDX];
        win_pkt.rd_arch  = req_rd_arch[int'(winner)*ARF_IDX +: ARF_IDX];
        win_pkt.rd_phy   = req_rd_phy[int'(winner)*PRF_IDX +: PRF_IDX];
        win_pkt.rd_value = req_rd_value[int'(winner)*32 +: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr            <= '0;
            cdb_valid         <= 1'b0;
            cdb_q             <= '0;
            src_q             <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            cdb_valid <= hs;
            if (hs) begin
                cdb_q  <= win_pkt;
                src_q  <= winner;
                rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
            end
            if (!flush && ($countones(req_valid) >= 2) && (perf_conflict_cnt != '1))
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end

    assign cdb_rob_id   = cdb_q.rob_id;
    assign cdb_rd_arch  = cdb_q.rd_arch;
    assign cdb_rd_phy   = cdb_q.rd_phy;
    assign cdb_rd_value = cdb_q.rd_value;
    assign cdb_src      = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with NUM_REQ=2: reset, single requester, rotation, flush, late requester, saturation.
module tb_cdb_arbiter;

    localparam int N  = 2;
    localparam int RB = 5;
    localparam int PB = 6;
    localparam int AB = 5;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*RB-1:0]   req_rob_id;
    logic [N*AB-1:0]   req_rd_arch;
    logic [N*PB-1:0]   req_rd_phy;
    logic [N*32-1:0]   req_rd_value;
    logic              cdb_valid;
    logic [RB-1:0]     cdb_rob_id;
    logic [AB-1:0]     cdb_rd_arch;
    logic [PB-1:0]     cdb_rd_phy;
    logic [31:0]       cdb_rd_value;
    logic              cdb_src;
    logic [31:0]       perf_conflict_cnt;

    int checks;
    int errors;

    cdb_arbiter #(.NUM_REQ(N), .ROB_IDX(RB), .PRF_IDX(PB), .ARF_IDX(AB)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_rob_id        (req_rob_id),
        .req_rd_arch       (req_rd_arch),
        .req_rd_phy        (req_rd_phy),
        .req_rd_value      (req_rd_value),
        .cdb_valid         (cdb_valid),
        .cdb_rob_id        (cdb_rob_id),
        .cdb_rd_arch       (cdb_rd_arch),
        .cdb_rd_phy        (cdb_rd_phy),
        .cdb_rd_value      (cdb_rd_value),
        .cdb_src           (cdb_src),
        .perf_conflict_cnt (perf_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [RB-1:0] rob, input logic [AB-1:0] arch,
                           input logic [PB-1:0] phy, input logic [31:0] val);
        req_rob_id[i*RB +: RB]    = rob;
        req_rd_arch[i*AB +: AB]   = arch;
        req_rd_phy[i*PB +: PB]    = phy;
        req_rd_value[i*32 +: 32]  = val;
    endtask

    // Registered outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        flush     = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        req_valid    = 2'b11;
        req_rob_id   = '0;
        req_rd_arch  = '0;
        req_rd_phy   = '0;
        req_rd_value = '0;

        // Reset with both requesters valid: no grant, all outputs cleared.
        @(negedge clk);
        #1 chk("rst_ready", 32'(req_ready), 32'h0);
        tick();
        tick();
        chk("rst_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("rst_rob_id", 32'(cdb_rob_id), 32'h0);
        chk("rst_rd_value", cdb_rd_value, 32'h0);
        chk("rst_src", 32'(cdb_src), 32'h0);
        chk("rst_perf", perf_conflict_cnt, 32'h0);

        // Idle after reset.
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        #1 chk("idle_ready", 32'(req_ready), 32'h0);
        tick();
        chk("idle_cdb_valid", 32'(cdb_valid), 32'h0);

        // Only requester 1 valid while rr_ptr=0.
        @(negedge clk);
        set_req(1, 5'd7, 5'd3, 6'd33, 32'hDEADBEEF);
        req_valid = 2'b10;
        #1 chk("single_ready", 32'(req_ready), 32'h2);
        tick();
        chk("single_valid", 32'(cdb_valid), 32'h1);
        chk("single_rob", 32'(cdb_rob_id), 32'd7);
        chk("single_arch", 32'(cdb_rd_arch), 32'd3);
        chk("single_phy", 32'(cdb_rd_phy), 32'd33);
        chk("single_value", cdb_rd_value, 32'hDEADBEEF);
        chk("single_src", 32'(cdb_src), 32'h1);
        @(negedge clk);
        req_valid = '0;
        tick();
        chk("single_drop_valid", 32'(cdb_valid), 32'h0);
        chk("single_hold_value", cdb_rd_value, 32'hDEADBEEF);

        // Both valid for 6 cycles from reset: grants alternate 0,1,0,1,0,1.
        do_reset();
        set_req(0, 5'd1, 5'd10, 6'd20, 32'h0000_00A0);
        set_req(1, 5'd2, 5'd11, 6'd21, 32'h0000_00B1);
        for (int c = 0; c < 6; c++) begin
            if (c != 0) @(negedge clk);
            req_valid = 2'b11;
            #1 chk($sformatf("rot_ready_c%0d", c), 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk($sformatf("rot_src_c%0d", c), 32'(cdb_src), 32'(c % 2));
            chk($sformatf("rot_rob_c%0d", c), 32'(cdb_rob_id), (c % 2 == 0) ? 32'd1 : 32'd2);
        end
        chk("rot_perf", perf_conflict_cnt, 32'd6);
        @(negedge clk);
        req_valid = '0;

        // Flush in cycle 3 while both valid.
        do_reset();
        req_valid = 2'b11;
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        chk("fl_pre_src", 32'(cdb_src), 32'h0);
        @(negedge clk);
        flush = 1'b1;
        #1 chk("fl_ready", 32'(req_ready), 32'h0);
        chk("fl_old_bcast_visible", 32'(cdb_valid), 32'h1);
        tick();
        chk("fl_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("fl_perf", perf_conflict_cnt, 32'd3);
        chk("fl_src_hold", 32'(cdb_src), 32'h0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("fl_resume_ready", 32'(req_ready), 32'h2);
        tick();
        chk("fl_resume_valid", 32'(cdb_valid), 32'h1);
        chk("fl_resume_src", 32'(cdb_src), 32'h1);
        chk("fl_resume_perf", perf_conflict_cnt, 32'd4);
        @(negedge clk);
        req_valid = '0;

        // Req 0 alone for cycles 0-4, req 1 joins in cycle 5 with rd_arch=0.
        do_reset();
        set_req(0, 5'd4, 5'd4, 6'd40, 32'h1111_0000);
        set_req(1, 5'd9, 5'd0, 6'd41, 32'h2222_0001);
        req_valid = 2'b01;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            #1 chk($sformatf("late_r0_ready_c%0d", c), 32'(req_ready), 32'h1);
            tick();
        end
        chk("late_r0_src", 32'(cdb_src), 32'h0);
        @(negedge clk);
        req_valid = 2'b11;
        #1 chk("late_r1_ready", 32'(req_ready), 32'h2);
        tick();
        chk("late_r1_valid", 32'(cdb_valid), 32'h1);
        chk("late_r1_src", 32'(cdb_src), 32'h1);
        chk("late_r1_arch0", 32'(cdb_rd_arch), 32'h0);
        chk("late_r1_rob", 32'(cdb_rob_id), 32'd9);
        chk("late_perf", perf_conflict_cnt, 32'd1);

        // Saturation of the conflict counter.
        @(negedge clk);
        req_valid = '0;
        force dut.perf_conflict_cnt = 32'hFFFF_FFFE;
        #1 release dut.perf_conflict_cnt;
        chk("sat_preload", perf_conflict_cnt, 32'hFFFF_FFFE);
        req_valid = 2'b11;
        tick();
        chk("sat_c0", perf_conflict_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        chk("sat_no_wrap", perf_conflict_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
